// File: rtl/neat_gene_pkg.sv
// Shared gene layout for the crossover/mutate pipeline: field offsets, type encoding, default masks.
// Gene word is {key, type, attr[NUM_ATTR-1..0]} with attr[0] in the least significant bits.
package neat_gene_pkg;

  typedef enum logic {
    GENE_NODE = 1'b0,
    GENE_CONN = 1'b1
  } gene_type_e;

  localparam int DEF_KEY_SZ   = 16;
  localparam int DEF_ATTR_SZ  = 8;
  localparam int DEF_NUM_ATTR = 3;

  localparam logic [DEF_NUM_ATTR*DEF_ATTR_SZ-1:0] DEF_NODE_MASK = {8'h07, 8'h0F, 8'hFF};
  localparam logic [DEF_NUM_ATTR*DEF_ATTR_SZ-1:0] DEF_CONN_MASK = {8'h00, 8'h00, 8'h01};
  localparam logic [DEF_ATTR_SZ-1:0]              DEF_HALF      = 8'h40;

  function automatic int attr_lsb(input int idx, input int attr_sz);
    return idx * attr_sz;
  endfunction

  function automatic int type_pos(input int num_attr, input int attr_sz);
    return num_attr * attr_sz;
  endfunction

  function automatic int key_lsb(input int num_attr, input int attr_sz);
    return num_attr * attr_sz + 1;
  endfunction

endpackage

// File: rtl/attr_mutate_lane.sv
// One attribute lane: replaces the attribute with a masked random value when the select byte wins.
// Purely combinational; no handshake of its own.
module attr_mutate_lane #(
  parameter int ATTR_SZ = 8
) (
  input  logic [ATTR_SZ-1:0] attr_in,
  input  logic [ATTR_SZ-1:0] sel_byte,
  input  logic [ATTR_SZ-1:0] val_byte,
  input  logic [ATTR_SZ-1:0] prob,
  input  logic [ATTR_SZ-1:0] mask,
  output logic [ATTR_SZ-1:0] attr_out,
  output logic               mutated
);

  always_comb begin
    mutated  = (sel_byte < prob);
    attr_out = mutated ? (val_byte & mask) : attr_in;
  end

endmodule

// File: rtl/gene_xover_mutate_pipe.sv
// Gene crossover (stage 1) then per-attribute mutation (stage 2); optional GENE_XOVER_MUTATE_STATS_EN counters.
// Latency 2 cycles from input transfer to out_valid, 1 gene/cycle throughput.
// Backpressure: out_ready stalls both stages combinationally back to in_ready; at most 2 genes held.
module gene_xover_mutate_pipe
  import neat_gene_pkg::*;
#(
  parameter int KEY_SZ   = DEF_KEY_SZ,
  parameter int ATTR_SZ  = DEF_ATTR_SZ,
  parameter int NUM_ATTR = DEF_NUM_ATTR,
  parameter logic [NUM_ATTR*ATTR_SZ-1:0] NODE_MASK = DEF_NODE_MASK,
  parameter logic [NUM_ATTR*ATTR_SZ-1:0] CONN_MASK = DEF_CONN_MASK,
  parameter logic [ATTR_SZ-1:0]          HALF      = DEF_HALF,
  localparam int GENE_W = KEY_SZ + 1 + NUM_ATTR*ATTR_SZ,
  localparam int RAND_W = ATTR_SZ*(1 + 2*NUM_ATTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [GENE_W-1:0] gene1,
  input  logic [GENE_W-1:0] gene2,
  input  logic              bias,
  input  logic [ATTR_SZ-1:0] mutation_prob,
  input  logic              in_last,
  input  logic [RAND_W-1:0] rand_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [GENE_W-1:0] out_gene,
  output logic              out_last,
  output logic [15:0]       out_idx
`ifdef GENE_XOVER_MUTATE_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       xover_cnt,
  output logic [15:0]       mut_cnt
`endif
);

  localparam int ATTR_W   = NUM_ATTR*ATTR_SZ;
  localparam int TYPE_POS = type_pos(NUM_ATTR, ATTR_SZ);
  localparam int KEY_LSB  = key_lsb(NUM_ATTR, ATTR_SZ);
  localparam int MRND_W   = RAND_W - ATTR_SZ;

  logic              s1_valid_q, s1_valid_d;
  logic [GENE_W-1:0] s1_gene_q,  s1_gene_d;
  logic [MRND_W-1:0] s1_rnd_q,   s1_rnd_d;
  logic [ATTR_SZ-1:0] s1_prob_q, s1_prob_d;
  logic              s1_last_q,  s1_last_d;

  logic              out_valid_q, out_valid_d;
  logic [GENE_W-1:0] out_gene_q,  out_gene_d;
  logic              out_last_q,  out_last_d;
  logic [15:0]       out_idx_q,   out_idx_d;

  logic              out_adv, s1_adv, in_xfer, out_xfer, take_gene2;
  logic              s1_is_conn;
  logic [ATTR_W-1:0] mut_attr;
  logic [NUM_ATTR-1:0] mut_hit;

  assign s1_is_conn = (s1_gene_q[TYPE_POS] == GENE_CONN);

  for (genvar i = 0; i < NUM_ATTR; i++) begin : g_lane
    attr_mutate_lane #(.ATTR_SZ(ATTR_SZ)) u_lane (
      .attr_in  (s1_gene_q[attr_lsb(i, ATTR_SZ) +: ATTR_SZ]),
      .sel_byte (s1_rnd_q[(2*i)*ATTR_SZ +: ATTR_SZ]),
      .val_byte (s1_rnd_q[(2*i+1)*ATTR_SZ +: ATTR_SZ]),
      .prob     (s1_prob_q),
      .mask     (s1_is_conn ? CONN_MASK[attr_lsb(i, ATTR_SZ) +: ATTR_SZ]
                            : NODE_MASK[attr_lsb(i, ATTR_SZ) +: ATTR_SZ]),
      .attr_out (mut_attr[attr_lsb(i, ATTR_SZ) +: ATTR_SZ]),
      .mutated  (mut_hit[i])
    );
  end

  always_comb begin
    out_adv  = !out_valid_q || out_ready;
    s1_adv   = !s1_valid_q || out_adv;
    in_xfer  = in_valid && s1_adv;
    out_xfer = out_valid_q && out_ready;
    // Disjoint/excess genes (key mismatch) always inherit from the fitter parent.
    take_gene2 = (gene1[KEY_LSB +: KEY_SZ] == gene2[KEY_LSB +: KEY_SZ]) && !bias
                 && (rand_in[ATTR_SZ-1:0] > HALF);

    s1_valid_d = s1_valid_q;
    s1_gene_d  = s1_gene_q;
    s1_rnd_d   = s1_rnd_q;
    s1_prob_d  = s1_prob_q;
    s1_last_d  = s1_last_q;
    if (s1_adv) s1_valid_d = in_valid;
    if (in_xfer) begin
      s1_gene_d = take_gene2 ? gene2 : gene1;
      s1_rnd_d  = rand_in[RAND_W-1:ATTR_SZ];
      s1_prob_d = mutation_prob;
      s1_last_d = in_last;
    end

    out_valid_d = out_valid_q;
    out_gene_d  = out_gene_q;
    out_last_d  = out_last_q;
    if (out_adv) out_valid_d = s1_valid_q;
    if (out_adv && s1_valid_q) begin
      out_gene_d = {s1_gene_q[GENE_W-1:ATTR_W], mut_attr};
      out_last_d = s1_last_q;
    end

    out_idx_d = out_idx_q;
    if (out_xfer) out_idx_d = out_last_q ? 16'd0 : out_idx_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_gene_q   <= '0;
      s1_rnd_q    <= '0;
      s1_prob_q   <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_gene_q  <= '0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_gene_q   <= s1_gene_d;
      s1_rnd_q    <= s1_rnd_d;
      s1_prob_q   <= s1_prob_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_gene_q  <= out_gene_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = out_valid_q;
  assign out_gene  = out_gene_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;

`ifdef GENE_XOVER_MUTATE_STATS_EN
  logic        s1_xover_q,  s1_xover_d;
  logic        out_xover_q, out_xover_d;
  logic [3:0]  out_nmut_q,  out_nmut_d;
  logic [3:0]  nmut;
  logic [16:0] mut_sum;
  logic [15:0] xover_cnt_q, xover_cnt_d;
  logic [15:0] mut_cnt_q,   mut_cnt_d;

  always_comb begin
    nmut = '0;
    for (int i = 0; i < NUM_ATTR; i++) nmut = nmut + 4'(mut_hit[i]);

    s1_xover_d  = s1_xover_q;
    out_xover_d = out_xover_q;
    out_nmut_d  = out_nmut_q;
    if (in_xfer) s1_xover_d = take_gene2;
    if (out_adv && s1_valid_q) begin
      out_xover_d = s1_xover_q;
      out_nmut_d  = nmut;
    end

    // Clear takes priority over a same-cycle increment.
    mut_sum     = {1'b0, mut_cnt_q} + 17'(out_nmut_q);
    xover_cnt_d = xover_cnt_q;
    mut_cnt_d   = mut_cnt_q;
    if (stats_clr) begin
      xover_cnt_d = '0;
      mut_cnt_d   = '0;
    end else if (out_xfer) begin
      if (out_xover_q && xover_cnt_q != 16'hFFFF) xover_cnt_d = xover_cnt_q + 16'd1;
      mut_cnt_d = mut_sum[16] ? 16'hFFFF : mut_sum[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_xover_q  <= 1'b0;
      out_xover_q <= 1'b0;
      out_nmut_q  <= '0;
      xover_cnt_q <= '0;
      mut_cnt_q   <= '0;
    end else begin
      s1_xover_q  <= s1_xover_d;
      out_xover_q <= out_xover_d;
      out_nmut_q  <= out_nmut_d;
      xover_cnt_q <= xover_cnt_d;
      mut_cnt_q   <= mut_cnt_d;
    end
  end

  assign xover_cnt = xover_cnt_q;
  assign mut_cnt   = mut_cnt_q;
`else
  logic unused_mut_hit;
  assign unused_mut_hit = ^mut_hit;
`endif

endmodule

// File: tb/tb_gene_xover_mutate_pipe.sv
// Scoreboard bench for gene_xover_mutate_pipe: driver pushes model results, negedge monitor pops on output transfer.
module tb_gene_xover_mutate_pipe;

  localparam int KEY_SZ   = 16;
  localparam int ATTR_SZ  = 8;
  localparam int NUM_ATTR = 3;
  localparam int GENE_W   = KEY_SZ + 1 + NUM_ATTR*ATTR_SZ;
  localparam int RAND_W   = ATTR_SZ*(1 + 2*NUM_ATTR);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [GENE_W-1:0] gene1 = '0;
  logic [GENE_W-1:0] gene2 = '0;
  logic              bias = 1'b0;
  logic [7:0]        mutation_prob = '0;
  logic              in_last = 1'b0;
  logic [RAND_W-1:0] rand_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [GENE_W-1:0] out_gene;
  logic              out_last;
  logic [15:0]       out_idx;
`ifdef GENE_XOVER_MUTATE_STATS_EN
  logic              stats_clr = 1'b0;
  logic [15:0]       xover_cnt;
  logic [15:0]       mut_cnt;
`endif

  gene_xover_mutate_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .gene1(gene1), .gene2(gene2), .bias(bias),
    .mutation_prob(mutation_prob), .in_last(in_last), .rand_in(rand_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_gene(out_gene), .out_last(out_last), .out_idx(out_idx)
`ifdef GENE_XOVER_MUTATE_STATS_EN
    , .stats_clr(stats_clr), .xover_cnt(xover_cnt), .mut_cnt(mut_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [GENE_W-1:0] gene;
    logic              last;
    logic [15:0]       idx;
    int                lat;
    bit                xo;
    int                nm;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  int          n_acc = 0;
  int          m_x = 0;
  int          m_m = 0;
  logic [15:0] exp_idx = '0;
  logic [7:0]  node_m [NUM_ATTR] = '{8'hFF, 8'h0F, 8'h07};
  logic [7:0]  conn_m [NUM_ATTR] = '{8'h01, 8'h00, 8'h00};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain rule application on unpacked fields.
  function automatic logic [GENE_W-1:0] ref_gene(input logic [GENE_W-1:0] g1, input logic [GENE_W-1:0] g2,
      input logic b, input logic [7:0] p, input logic [RAND_W-1:0] r, output bit xo, output int nm);
    logic [GENE_W-1:0] res;
    logic [7:0] sel, val, m;
    xo  = (g1[GENE_W-1 -: KEY_SZ] == g2[GENE_W-1 -: KEY_SZ]) && !b && (r[7:0] > 8'h40);
    res = xo ? g2 : g1;
    nm  = 0;
    for (int i = 0; i < NUM_ATTR; i++) begin
      sel = r[8*(1+2*i) +: 8];
      val = r[8*(2+2*i) +: 8];
      m   = res[NUM_ATTR*8] ? conn_m[i] : node_m[i];
      if (sel < p) begin
        res[8*i +: 8] = val & m;
        nm++;
      end
    end
    return res;
  endfunction

  function automatic logic [GENE_W-1:0] mk(input logic [15:0] key, input logic typ,
      input logic [7:0] a2, input logic [7:0] a1, input logic [7:0] a0);
    return {key, typ, a2, a1, a0};
  endfunction

  function automatic logic [RAND_W-1:0] mkr(input logic [7:0] b0, input logic [7:0] s0, input logic [7:0] v0,
      input logic [7:0] s1, input logic [7:0] v1, input logic [7:0] s2, input logic [7:0] v2);
    return {v2, s2, v1, s1, v0, s0, b0};
  endfunction

  function automatic logic [GENE_W-1:0] rgene();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[GENE_W-1:0];
  endfunction

  function automatic logic [RAND_W-1:0] rrand();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[RAND_W-1:0];
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [GENE_W-1:0] g1, input logic [GENE_W-1:0] g2, input logic b,
      input logic [7:0] p, input logic [RAND_W-1:0] r, input logic last, input bit chk_lat);
    exp_t e;
    bit ok;
    gene1 = g1; gene2 = g2; bias = b; mutation_prob = p; rand_in = r; in_last = last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e.gene = ref_gene(g1, g2, b, p, r, e.xo, e.nm);
        e.last = last;
        e.idx  = exp_idx;
        e.lat  = chk_lat ? cyc + 2 : -1;
        exp_q.push_back(e);
        exp_idx = last ? 16'd0 : exp_idx + 16'd1;
        n_acc++;
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: compares every output transfer against the head of the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      m_x = 0;
      m_m = 0;
    end else begin
`ifdef GENE_XOVER_MUTATE_STATS_EN
      chk("xover_cnt", 64'(xover_cnt), 64'(m_x));
      chk("mut_cnt", 64'(mut_cnt), 64'(m_m));
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_gene", 64'(out_gene), 64'(e.gene));
          chk("out_last", 64'(out_last), 64'(e.last));
          chk("out_idx", 64'(out_idx), 64'(e.idx));
          if (e.lat >= 0) chk("latency_cycle", 64'(cyc), 64'(e.lat));
`ifdef GENE_XOVER_MUTATE_STATS_EN
          if (!stats_clr) begin
            if (e.xo && m_x < 65535) m_x++;
            m_m = (m_m + e.nm > 65535) ? 65535 : m_m + e.nm;
          end
`endif
        end
      end
`ifdef GENE_XOVER_MUTATE_STATS_EN
      if (stats_clr) begin
        m_x = 0;
        m_m = 0;
      end
`endif
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [GENE_W-1:0] ga, gb;
    int base;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_idx", 64'(out_idx), 64'd0);
    chk("rst_out_gene", 64'(out_gene), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Crossover selection with latency checks.
    ga = mk(16'h0005, 1'b0, 8'h11, 8'h22, 8'h33);
    gb = mk(16'h0005, 1'b0, 8'h44, 8'h55, 8'h66);
    send(ga, gb, 1'b0, 8'h00, mkr(8'h41, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    send(ga, gb, 1'b0, 8'h00, mkr(8'h40, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    send(ga, gb, 1'b1, 8'h00, mkr(8'h41, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    send(ga, mk(16'h0006, 1'b0, 8'h44, 8'h55, 8'h66), 1'b0, 8'h00, mkr(8'h41, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);

    // Mutation masks for node and conn genes, and probability extremes.
    ga = mk(16'h0007, 1'b0, 8'h33, 8'h44, 8'h55);
    send(ga, ga, 1'b1, 8'h80, mkr(8'h00, 8'h10, 8'hAB, 8'h7F, 8'hFF, 8'h90, 8'h12), 1'b0, 1'b0);
    ga = mk(16'h0008, 1'b1, 8'h33, 8'h44, 8'h55);
    send(ga, ga, 1'b1, 8'h80, mkr(8'h00, 8'h10, 8'hAB, 8'h7F, 8'hFF, 8'h90, 8'h12), 1'b1, 1'b0);
    send(ga, ga, 1'b1, 8'h00, mkr(8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF), 1'b0, 1'b0);
    ga = mk(16'h0009, 1'b0, 8'h33, 8'h44, 8'h55);
    send(ga, ga, 1'b1, 8'hFF, mkr(8'h00, 8'hFF, 8'hAA, 8'hFE, 8'hBB, 8'h00, 8'hCC), 1'b1, 1'b0);
    drain();

    // Backpressure: 6-gene stream with out_ready low for 3 cycles.
    rdy_mode = 1;
    base = n_acc;
    fork
      begin
        for (int k = 0; k < 6; k++) send(rgene(), rgene(), $urandom_range(0, 1), 8'($urandom), rrand(), k == 5, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_genes_held", 64'(n_acc - base), 64'd2);
        @(posedge clk);
        #1 rdy_mode = 0;
      end
    join
    send(rgene(), rgene(), 1'b0, 8'h00, rrand(), 1'b0, 1'b0);
    drain();

    // Reset with two genes in flight.
    rdy_mode = 1;
    send(rgene(), rgene(), 1'b0, 8'h20, rrand(), 1'b0, 1'b0);
    send(rgene(), rgene(), 1'b0, 8'h20, rrand(), 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_idx", 64'(out_idx), 64'd0);
    exp_q.delete();
    exp_idx = '0;
    rdy_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    send(rgene(), rgene(), 1'b0, 8'h00, rrand(), 1'b0, 1'b0);
    drain();

    // Randomized traffic with random backpressure and idle gaps.
    rdy_mode = 2;
    for (int n = 0; n < 400; n++) begin
      ga = rgene();
      gb = rgene();
      if ($urandom_range(0, 1) != 0) gb[GENE_W-1 -: KEY_SZ] = ga[GENE_W-1 -: KEY_SZ];
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(ga, gb, ($urandom_range(0, 3) == 0), 8'($urandom), rrand(), ($urandom_range(0, 7) == 0), 1'b0);
    end
    rdy_mode = 0;
    drain();

`ifdef GENE_XOVER_MUTATE_STATS_EN
    ga = mk(16'h0005, 1'b0, 8'h11, 8'h22, 8'h33);
    gb = mk(16'h0005, 1'b0, 8'h44, 8'h55, 8'h66);
    for (int n = 0; n < 70000; n++) send(ga, gb, 1'b0, 8'h80, rrand() | RAND_W'(8'hFF), 1'b0, 1'b0);
    drain();
    @(negedge clk);
    chk("xover_cnt_saturated", 64'(xover_cnt), 64'hFFFF);
    @(posedge clk);
    #1;
    send(ga, gb, 1'b0, 8'h80, mkr(8'hFF, 0, 1, 0, 1, 0, 1), 1'b0, 1'b0);
    stats_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 stats_clr = 1'b0;
    @(negedge clk);
    chk("clr_beats_incr_xover", 64'(xover_cnt), 64'd0);
    chk("clr_beats_incr_mut", 64'(mut_cnt), 64'd0);
    @(posedge clk);
    #1;
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
